scan_select_mux: RTL and testbench

- Parametrised N-channel, W-bit registered channel selector for DE1-SoC/DE0-CV lab designs.
- Drives switch-sourced data buses onto LEDR/HEX display logic.
- Three modes:
  - MANUAL: an external select input picks the channel.
  - SCAN: the channel auto-rotates every DWELL clocks.
  - HOLD: the output and channel are frozen.
- Outputs are registered. The block reports the current channel, pulses on every channel change, and flags out-of-range selects.

---
 rtl/scan_select_mux_if.sv | 26 ++
 rtl/scan_select_mux.sv | 95 +++++++++
 tb/tb_scan_select_mux.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/scan_select_mux_if.sv
// Bus bundle for scan_select_mux: control/data in from the master, the
// registered selection results back out.
interface scan_select_mux_if #(
   parameter int W = 4,
   parameter int N = 2
);
   localparam int SELW = (N > 1) ? $clog2(N) : 1;

   logic [1:0]      mode;
   logic [SELW-1:0] sel;
   logic [N*W-1:0]  data_in;
   logic [W-1:0]    data_out;
   logic [SELW-1:0] chan;
   logic            chan_change;
   logic            sel_err;

   modport master (
      output mode, sel, data_in,
      input  data_out, chan, chan_change, sel_err
   );

   modport slave (
      input  mode, sel, data_in,
      output data_out, chan, chan_change, sel_err
   );
endinterface

// File: rtl/scan_select_mux.sv
// N-channel, W-bit registered channel selector with MANUAL / SCAN / HOLD
// modes. Every output comes from a flop; inputs only feed next-state logic.
module scan_select_mux #(
   parameter int W     = 4,
   parameter int N     = 2,
   parameter int DWELL = 8
) (
   input  logic             Clock,
   input  logic             Resetn,
   scan_select_mux_if.slave bus
);
   localparam int SELW = (N > 1) ? $clog2(N) : 1;
   localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
   localparam logic [SELW-1:0] CHAN_TOP = SELW'(N - 1);
   localparam logic [CW-1:0]   CNT_TOP  = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      MANUAL = 2'b00,
      SCAN   = 2'b01,
      HOLD   = 2'b10
   } mode_e;

   mode_e                md;
   logic [N-1:0][W-1:0]  ch;
   logic [SELW-1:0]      chan_q, chan_nxt;
   logic [CW-1:0]        cnt_q, cnt_nxt;
   logic [W-1:0]         data_q;
   logic                 chg_q, err_q, err_nxt, upd;

   assign ch = bus.data_in;

   // Decode the mode pins; the reserved code behaves exactly like HOLD.
   always_comb begin
      case (bus.mode)
         2'b00:   md = MANUAL;
         2'b01:   md = SCAN;
         default: md = HOLD;
      endcase
   end

   // Next channel, dwell count and select-error flag for the sampled mode.
   always_comb begin
      chan_nxt = chan_q;
      cnt_nxt  = cnt_q;
      err_nxt  = err_q;
      upd      = 1'b0;
      case (md)
         MANUAL: begin
            upd     = 1'b1;
            cnt_nxt = '0;
            if ({1'b0, bus.sel} < N_EXT) begin
               chan_nxt = bus.sel;
               err_nxt  = 1'b0;
            end else begin
               err_nxt  = 1'b1;
            end
         end
         SCAN: begin
            upd     = 1'b1;
            err_nxt = 1'b0;
            if (cnt_q == CNT_TOP) begin
               cnt_nxt  = '0;
               chan_nxt = (chan_q == CHAN_TOP) ? '0 : chan_q + 1'b1;
            end else begin
               cnt_nxt  = cnt_q + 1'b1;
            end
         end
         default: ;  // HOLD: everything keeps its value
      endcase
   end

   // State and output registers; reset clears everything, aborting any scan.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         chan_q <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         chg_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         chan_q <= chan_nxt;
         cnt_q  <= cnt_nxt;
         err_q  <= err_nxt;
         chg_q  <= (chan_nxt != chan_q);
         if (upd) data_q <= ch[chan_nxt];
      end
   end

   assign bus.data_out    = data_q;
   assign bus.chan        = chan_q;
   assign bus.chan_change = chg_q;
   assign bus.sel_err     = err_q;
endmodule

// File: tb/tb_scan_select_mux.sv
// Directed-vector bench for scan_select_mux: four instances cover the main
// N=4/DWELL=3 config, a non-power-of-two N=3, DWELL=1 and N=1.
module tb_scan_select_mux;
   logic clk = 1'b0;
   logic rstn;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   scan_select_mux_if #(.W(4), .N(4)) b0 ();
   scan_select_mux_if #(.W(4), .N(3)) b1 ();
   scan_select_mux_if #(.W(4), .N(2)) b2 ();
   scan_select_mux_if #(.W(4), .N(1)) b3 ();

   scan_select_mux #(.W(4), .N(4), .DWELL(3)) u0 (.Clock(clk), .Resetn(rstn), .bus(b0.slave));
   scan_select_mux #(.W(4), .N(3), .DWELL(3)) u1 (.Clock(clk), .Resetn(rstn), .bus(b1.slave));
   scan_select_mux #(.W(4), .N(2), .DWELL(1)) u2 (.Clock(clk), .Resetn(rstn), .bus(b2.slave));
   scan_select_mux #(.W(4), .N(1), .DWELL(2)) u3 (.Clock(clk), .Resetn(rstn), .bus(b3.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk0(input string tag, input int d, input int c, input int g, input int e);
      chk({tag, ".data"}, 32'(b0.data_out), d);
      chk({tag, ".chan"}, 32'(b0.chan), c);
      chk({tag, ".chg"},  32'(b0.chan_change), g);
      chk({tag, ".err"},  32'(b0.sel_err), e);
   endtask

   task automatic chk1(input string tag, input int d, input int c, input int g, input int e);
      chk({tag, ".data"}, 32'(b1.data_out), d);
      chk({tag, ".chan"}, 32'(b1.chan), c);
      chk({tag, ".chg"},  32'(b1.chan_change), g);
      chk({tag, ".err"},  32'(b1.sel_err), e);
   endtask

   // Advance one rising edge and land 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int abcd [4];
      abcd = '{4'hA, 4'hB, 4'hC, 4'hD};

      rstn = 1'b0;
      b0.mode = 2'b00; b0.sel = 2'd0; b0.data_in = 16'hDCBA;
      b1.mode = 2'b00; b1.sel = 2'd0; b1.data_in = 12'hCBA;
      b2.mode = 2'b00; b2.sel = 1'b0; b2.data_in = 8'h21;
      b3.mode = 2'b00; b3.sel = 1'b0; b3.data_in = 4'h7;
      #12;
      chk0("rst", 0, 0, 0, 0);

      // MANUAL select of channel 2, then live tracking of that channel
      rstn = 1'b1;
      b0.sel = 2'd2;
      step(); chk0("man_sel2", 4'hC, 2, 1, 0);
      step(); chk0("man_hold2", 4'hC, 2, 0, 0);
      b0.data_in = 16'hD5BA;
      #1; chk("no_comb_path", 32'(b0.data_out), 4'hC);
      step(); chk0("man_live", 4'h5, 2, 0, 0);

      // N=3: out-of-range select keeps channel, flags error
      b1.sel = 2'd1;
      step(); chk1("n3_sel1", 4'hB, 1, 1, 0);
      b1.sel = 2'd3;
      step(); chk1("n3_sel3", 4'hB, 1, 0, 1);
      b1.sel = 2'd0;
      step(); chk1("n3_sel0", 4'hA, 0, 1, 0);

      // Park b0 on channel 0, then SCAN through a full wrap
      b0.data_in = 16'hDCBA;
      b0.sel = 2'd0;
      step(); chk0("park0", 4'hA, 0, 1, 0);
      b0.mode = 2'b01;
      b0.sel  = 2'd2;  // ignored while scanning
      for (int k = 1; k <= 12; k++) begin
         step();
         chk0($sformatf("scan%0d", k), abcd[(k/3)%4], (k/3)%4, (k%3 == 0) ? 1 : 0, 0);
      end

      // Reach chan 1 with one cycle of dwell spent, then HOLD/reserved
      for (int k = 0; k < 4; k++) step();
      chk0("pre_hold", 4'hB, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         b0.mode    = (k % 2 == 0) ? 2'b10 : 2'b11;
         b0.data_in = 16'(16'h1234 + k);
         step();
         chk0($sformatf("hold%0d", k), 4'hB, 1, 0, 0);
      end
      b0.mode    = 2'b01;
      b0.data_in = 16'h1234;
      step(); chk0("resume1", 4'h3, 1, 0, 0);
      step(); chk0("resume2", 4'h2, 2, 1, 0);

      // Scan on to chan 3, then reset asynchronously between edges
      for (int k = 0; k < 3; k++) step();
      chk0("pre_rst", 4'h1, 3, 1, 0);
      rstn = 1'b0;
      #1; chk0("async_rst", 0, 0, 0, 0);
      step(); step();
      rstn = 1'b1;
      step(); chk0("rel1", 4'h4, 0, 0, 0);
      step(); chk0("rel2", 4'h4, 0, 0, 0);
      step(); chk0("rel3", 4'h3, 1, 1, 0);

      // DWELL=1: advance and pulse on every edge, including the wrap
      b2.mode = 2'b01;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("d1_chan%0d", k), 32'(b2.chan), k % 2);
         chk($sformatf("d1_chg%0d", k),  32'(b2.chan_change), 1);
         chk($sformatf("d1_data%0d", k), 32'(b2.data_out), (k % 2) ? 2 : 1);
      end

      // N=1: select 1 is out of range, channel never moves
      b3.sel = 1'b1;
      step();
      chk("n1_err",  32'(b3.sel_err), 1);
      chk("n1_chan", 32'(b3.chan), 0);
      chk("n1_chg",  32'(b3.chan_change), 0);
      chk("n1_data", 32'(b3.data_out), 4'h7);
      b3.mode = 2'b01;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("n1_scan_chan%0d", k), 32'(b3.chan), 0);
         chk($sformatf("n1_scan_chg%0d", k),  32'(b3.chan_change), 0);
         chk($sformatf("n1_scan_err%0d", k),  32'(b3.sel_err), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
